// File: rtl/mem_boot_loader_pkg.sv
// Shared definitions for the boot loader: FSM encoding, word width and
// a helper that classifies the byte-receiving states.
package mem_boot_loader_pkg;

  localparam int DATA_W     = 16;
  localparam int ADDR_W_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN   = 3'd1,
    ST_HI    = 3'd2,
    ST_LO    = 3'd3,
    ST_WRITE = 3'd4,
    ST_CHK   = 3'd5,
    ST_OK    = 3'd6,
    ST_FAIL  = 3'd7
  } state_t;

  // States in which the loader is waiting for a stream byte.
  function automatic logic is_rx_state(input state_t s);
    return (s == ST_LEN) || (s == ST_HI) || (s == ST_LO) || (s == ST_CHK);
  endfunction

  // States that make up an active load.
  function automatic logic is_busy_state(input state_t s);
    return is_rx_state(s) || (s == ST_WRITE);
  endfunction

endpackage

// File: rtl/mem_boot_loader_byte_timeout_ctr.sv
// Inter-byte watchdog: counts enabled cycles since the last clear and
// flags expiry when TIMEOUT cycles elapse without a clear. TIMEOUT=0 disables it.
module byte_timeout_ctr #(
  parameter int TIMEOUT = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit TO_ON = (TIMEOUT > 0);
  localparam logic [CW-1:0] LIMIT_C = TO_ON ? CW'(TIMEOUT - 1) : {CW{1'b0}};

  logic [CW-1:0] cnt_r;

  // Cycle counter; saturates at the limit so it never wraps back to zero.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_r <= {CW{1'b0}};
    end else if (enable && (cnt_r != LIMIT_C)) begin
      cnt_r <= cnt_r + CW'(1'b1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Expiry fires on the edge that would complete the TIMEOUT-th idle cycle.
  always_comb begin
    expired = 1'b0;
    if (TO_ON && enable && !clear && (cnt_r == LIMIT_C)) begin
      expired = 1'b1;
    end else begin
      expired = 1'b0;
    end
  end

endmodule

// File: rtl/mem_boot_loader.sv
// Boot loader: receives LEN / data / checksum bytes, writes 16-bit words to
// the memory write port and releases the CPU only after a verified image.
module mem_boot_loader
  import mem_boot_loader_pkg::*;
#(
  parameter int                ADDR_W    = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] BASE_ADDR = {ADDR_W{1'b0}},
  parameter int                TIMEOUT   = 1000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [7:0]        BYTE_IN,
  input  logic              BYTE_VALID,
  output logic              BYTE_READY,
  output logic [ADDR_W-1:0] ADDR,
  output logic              En,
  output logic [DATA_W-1:0] WD,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR,
  output logic              CPU_RST
);

  localparam logic [ADDR_W:0] FULL_IMAGE_C = {1'b1, {ADDR_W{1'b0}}};

  state_t            state_r, next_state_s;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wd_r;
  logic [ADDR_W:0]   remaining_r;
  logic [7:0]        csum_r;
  logic              ready_r, en_r, busy_r, done_r, err_r, cpu_rst_r;
  logic              ready_s, en_s, busy_s, done_s, err_s, cpu_rst_s;
  logic              accept_s, start_s, expired_s;

  assign accept_s = BYTE_VALID && ready_r;
  assign start_s  = START && ((state_r == ST_IDLE) || (state_r == ST_OK) ||
                              (state_r == ST_FAIL));

  byte_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (CLK),
    .rst     (RST),
    .clear   (accept_s || start_s),
    .enable  (is_rx_state(state_r)),
    .expired (expired_s)
  );

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state decode; an accepted byte takes priority over expiry.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE, ST_OK, ST_FAIL: begin
        if (start_s) next_state_s = ST_LEN;
        else         next_state_s = state_r;
      end
      ST_LEN: begin
        if (accept_s)       next_state_s = ST_HI;
        else if (expired_s) next_state_s = ST_FAIL;
        else                next_state_s = ST_LEN;
      end
      ST_HI: begin
        if (accept_s)       next_state_s = ST_LO;
        else if (expired_s) next_state_s = ST_FAIL;
        else                next_state_s = ST_HI;
      end
      ST_LO: begin
        if (accept_s)       next_state_s = ST_WRITE;
        else if (expired_s) next_state_s = ST_FAIL;
        else                next_state_s = ST_LO;
      end
      ST_WRITE: begin
        if (remaining_r == {{ADDR_W{1'b0}}, 1'b1}) next_state_s = ST_CHK;
        else                                      next_state_s = ST_HI;
      end
      ST_CHK: begin
        if (accept_s) begin
          if (BYTE_IN == csum_r) next_state_s = ST_OK;
          else                   next_state_s = ST_FAIL;
        end else if (expired_s) begin
          next_state_s = ST_FAIL;
        end else begin
          next_state_s = ST_CHK;
        end
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // FSM output decode from the upcoming state so registered outputs line up with it.
  always_comb begin
    ready_s   = is_rx_state(next_state_s);
    en_s      = (next_state_s == ST_WRITE);
    busy_s    = is_busy_state(next_state_s);
    done_s    = (next_state_s == ST_OK);
    err_s     = (next_state_s == ST_FAIL);
    cpu_rst_s = (next_state_s != ST_OK);
  end

  // Output flops.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ready_r   <= 1'b0;
      en_r      <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
      cpu_rst_r <= 1'b1;
    end else begin
      ready_r   <= ready_s;
      en_r      <= en_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
      err_r     <= err_s;
      cpu_rst_r <= cpu_rst_s;
    end
  end

  // Datapath: word assembly, running checksum, word count and address counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      addr_r      <= BASE_ADDR;
      wd_r        <= {DATA_W{1'b0}};
      remaining_r <= {(ADDR_W+1){1'b0}};
      csum_r      <= 8'h00;
    end else begin
      case (state_r)
        ST_IDLE, ST_OK, ST_FAIL: begin
          if (start_s) begin
            addr_r <= BASE_ADDR;
            csum_r <= 8'h00;
          end
        end
        ST_LEN: begin
          if (accept_s) begin
            remaining_r <= (BYTE_IN == 8'h00) ? FULL_IMAGE_C : (ADDR_W+1)'(BYTE_IN);
            csum_r      <= csum_r ^ BYTE_IN;
          end
        end
        ST_HI: begin
          if (accept_s) begin
            wd_r[15:8] <= BYTE_IN;
            csum_r     <= csum_r ^ BYTE_IN;
          end
        end
        ST_LO: begin
          if (accept_s) begin
            wd_r[7:0] <= BYTE_IN;
            csum_r    <= csum_r ^ BYTE_IN;
          end
        end
        ST_WRITE: begin
          // Address wraps naturally modulo 2^ADDR_W.
          addr_r      <= addr_r + ADDR_W'(1'b1);
          remaining_r <= remaining_r - (ADDR_W+1)'(1'b1);
        end
        ST_CHK: begin
          csum_r <= csum_r;
        end
        default: begin
          addr_r <= addr_r;
        end
      endcase
    end
  end

  assign BYTE_READY = ready_r;
  assign ADDR       = addr_r;
  assign En         = en_r;
  assign WD         = wd_r;
  assign BUSY       = busy_r;
  assign DONE       = done_r;
  assign ERR        = err_r;
  assign CPU_RST    = cpu_rst_r;

endmodule
